// File: rtl/spectrogram_frame_receiver.sv
// spectrogram_frame_receiver: deserializes 16x12-bit MSB-first frames against a sync pulse into a readable bank
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   sdi, sync       serial data and one-cycle frame sync (coincident with MSB of word 0)
//   word_data/index last completed word and its position (0 = RTC, k = CHk)
//   word_valid      one-cycle strobe for a new word
//   frame_done      one-cycle strobe with the last word of a frame
//   frame_error     one-cycle strobe when sync aborts a frame in progress
//   frame_ready     bank holds a complete, unaborted frame
//   rd_addr/rd_data combinational bank read port
module spectrogram_frame_receiver #(
  parameter int WORD_W  = 12,
  parameter int N_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  input  logic              sync,
  output logic [WORD_W-1:0] word_data,
  output logic [3:0]        word_index,
  output logic              word_valid,
  output logic              frame_done,
  output logic              frame_error,
  output logic              frame_ready,
  input  logic [3:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [3:0] LAST_WORD = 4'(N_WORDS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;
  logic [0:0]        r_state;
  logic [WORD_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic [3:0]        r_word_cnt;
  logic [WORD_W-1:0] r_data;
  logic [3:0]        r_index;
  logic              r_valid;
  logic              r_done;
  logic              r_err;
  logic              r_ready;
  logic [WORD_W-1:0] r_bank [N_WORDS];
  logic [WORD_W-1:0] w_word;
  assign w_word      = {r_shift[WORD_W-2:0], sdi};
  assign word_data   = r_data;
  assign word_index  = r_index;
  assign word_valid  = r_valid;
  assign frame_done  = r_done;
  assign frame_error = r_err;
  assign frame_ready = r_ready;
  assign rd_data     = r_bank[rd_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_data     <= '0;
      r_index    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) r_bank[i] <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      // sync always restarts word 0; it is only an error if it cuts a frame short
      if (sync) begin
        r_state    <= RECV;
        r_shift    <= WORD_W'(sdi);
        r_bit_cnt  <= BW'(1);
        r_word_cnt <= '0;
        r_err      <= (r_state == RECV);
        r_ready    <= 1'b0;
      end else if (r_state == RECV) begin
        r_shift <= w_word;
        if (r_bit_cnt == LAST_BIT) begin
          r_data             <= w_word;
          r_index            <= r_word_cnt;
          r_valid            <= 1'b1;
          r_bank[r_word_cnt] <= w_word;
          r_bit_cnt          <= '0;
          r_word_cnt         <= r_word_cnt + 4'd1;
          if (r_word_cnt == LAST_WORD) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_spectrogram_frame_receiver.sv
// tb_spectrogram_frame_receiver: directed scenario bench for spectrogram_frame_receiver
module tb_spectrogram_frame_receiver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdi = 1'b0;
  logic        sync = 1'b0;
  logic [11:0] word_data;
  logic [3:0]  word_index;
  logic        word_valid;
  logic        frame_done;
  logic        frame_error;
  logic        frame_ready;
  logic [3:0]  rd_addr = 4'd0;
  logic [11:0] rd_data;
  logic [11:0] tx [16];
  int vectors = 0;
  int miscompares = 0;
  int valid_seen = 0;

  spectrogram_frame_receiver #(.WORD_W(12), .N_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sync(sync),
    .word_data(word_data), .word_index(word_index), .word_valid(word_valid),
    .frame_done(frame_done), .frame_error(frame_error), .frame_ready(frame_ready),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic edge_drive(input logic s, input logic d);
    sync = s;
    sdi  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load_nominal();
    tx[0] = 12'hA5C;
    for (int k = 1; k < 16; k++) tx[k] = 12'(k * 12'h111);
  endtask

  task automatic send_frame(input int nbits, input logic exp_err0);
    for (int n = 0; n < nbits; n++) begin
      logic [11:0] w;
      logic ev;
      logic [3:0] k;
      w  = tx[n / 12];
      k  = 4'(n / 12);
      ev = (n % 12 == 11);
      edge_drive(n == 0, w[11 - (n % 12)]);
      if (word_valid) valid_seen++;
      vectors++;
      if (word_valid !== ev) begin
        miscompares++;
        $display("FAIL word_valid bit %0d: got %b want %b", n, word_valid, ev);
      end
      if (ev) begin
        rd_addr = k;
        #1;
        vectors++;
        if (word_index !== k || word_data !== w || rd_data !== w) begin
          miscompares++;
          $display("FAIL word %0d: idx %0d data %h rd %h want idx %0d data %h", k, word_index, word_data, rd_data, k, w);
        end
      end
      vectors++;
      if (frame_done !== (n == 191) || frame_ready !== (n == 191)) begin
        miscompares++;
        $display("FAIL done/ready bit %0d: got %b/%b want %b", n, frame_done, frame_ready, n == 191);
      end
      vectors++;
      if (frame_error !== (n == 0 && exp_err0)) begin
        miscompares++;
        $display("FAIL frame_error bit %0d: got %b want %b", n, frame_error, n == 0 && exp_err0);
      end
    end
  endtask

  task automatic check_bank(input logic zero);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      vectors++;
      if (rd_data !== (zero ? 12'h000 : tx[a])) begin
        miscompares++;
        $display("FAIL bank[%0d]: got %h want %h", a, rd_data, zero ? 12'h000 : tx[a]);
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({word_data, word_index, word_valid, frame_done, frame_error, frame_ready} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h want 0", {word_data, word_index, word_valid, frame_done, frame_error, frame_ready});
    end
    check_bank(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    load_nominal();
    valid_seen = 0;
    send_frame(192, 1'b0);
    edge_drive(1'b0, 1'b0);
    rd_addr = 4'd3;
    #1;
    vectors++;
    if (rd_data !== 12'h333 || frame_ready !== 1'b1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal after: rd %h ready %b done %b want 333 1 0", rd_data, frame_ready, frame_done);
    end
    vectors++;
    if (valid_seen !== 16) begin
      miscompares++;
      $display("FAIL nominal valid count: got %0d want 16", valid_seen);
    end
  endtask

  task automatic test_back_to_back();
    load_nominal();
    valid_seen = 0;
    send_frame(192, 1'b0);
    tx[0] = 12'h001;
    send_frame(192, 1'b0);
    vectors++;
    if (valid_seen !== 32) begin
      miscompares++;
      $display("FAIL back_to_back valid count: got %0d want 32", valid_seen);
    end
    rd_addr = 4'd0;
    #1;
    vectors++;
    if (rd_data !== 12'h001) begin
      miscompares++;
      $display("FAIL back_to_back bank[0]: got %h want 001", rd_data);
    end
  endtask

  task automatic test_abort();
    load_nominal();
    valid_seen = 0;
    send_frame(100, 1'b0);
    vectors++;
    if (valid_seen !== 8) begin
      miscompares++;
      $display("FAIL abort partial count: got %0d want 8", valid_seen);
    end
    tx[0] = 12'h123;
    tx[8] = 12'h0F0;
    send_frame(192, 1'b1);
    vectors++;
    if (valid_seen !== 24) begin
      miscompares++;
      $display("FAIL abort total count: got %0d want 24", valid_seen);
    end
  endtask

  task automatic test_idle_noise();
    for (int n = 0; n < 50; n++) begin
      edge_drive(1'b0, 1'($urandom_range(0, 1)));
      vectors++;
      if (word_valid !== 1'b0 || frame_done !== 1'b0 || frame_error !== 1'b0 || frame_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL idle noise %0d: valid %b done %b err %b ready %b want 0 0 0 1", n, word_valid, frame_done, frame_error, frame_ready);
      end
    end
    check_bank(1'b0);
  endtask

  task automatic test_reset_mid_frame();
    load_nominal();
    send_frame(60, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({word_data, word_index, word_valid, frame_done, frame_error, frame_ready} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid reset outputs: got %h want 0", {word_data, word_index, word_valid, frame_done, frame_error, frame_ready});
    end
    check_bank(1'b1);
    edge_drive(1'b0, 1'b1);
    edge_drive(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      edge_drive(1'b0, 1'(n % 2));
      vectors++;
      if (word_valid !== 1'b0 || frame_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL post reset quiet %0d: valid %b ready %b want 0 0", n, word_valid, frame_ready);
      end
    end
    tx[5] = 12'h9C3;
    send_frame(192, 1'b0);
    check_bank(1'b0);
  endtask

  initial begin
    #2;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_abort();
    test_idle_noise();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spectrogram_frame_receiver.md
# spectrogram_frame_receiver

Receiving end of the spectrogram serial link. The transmit side sends one frame per overflow event: 16 words of 12 bits each, MSB first, one bit per clock. Word 0 is the RTC timestamp and words 1–15 are channel counts CH1–CH15. This block deserializes that stream against a one-cycle frame sync, presents each word with a valid strobe, and stores the completed frame in a 16×12 register bank that the host reads asynchronously.

## Interface
Parameters:
- WORD_W, 12, bits per word
- N_WORDS, 16, words per frame (RTC plus 15 channels)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- sdi  input  1  serial data, MSB of each word first
- sync  input  1  one-cycle pulse, coincident with the MSB of word 0
- word_data  output  WORD_W  last completed word
- word_index  output  4  index of word_data (0 = RTC, k = CHk)
- word_valid  output  1  one-cycle strobe; word_data and word_index are new
- frame_done  output  1  one-cycle strobe with the word_valid of word 15
- frame_error  output  1  one-cycle strobe when a sync aborts a frame in progress
- frame_ready  output  1  bank holds a complete, unaborted frame
- rd_addr  input  4  bank read address
- rd_data  output  WORD_W  bank[rd_addr], combinational read

## Operation
- FSM states:
  - IDLE: sdi is ignored. sync=1 → RECV, with the sampled bit taken as bit 11 of word 0. bit_cnt=1, word_cnt=0.
  - RECV: each edge shifts sdi into shift_reg (left shift, LSB in) and increments bit_cnt.
- End of word (bit_cnt=11 at the sampling edge):
  - word_data ← {shift_reg[10:0], sdi}; word_index ← word_cnt; word_valid=1.
  - bank[word_cnt] ← the same value.
  - bit_cnt ← 0; word_cnt increments.
- End of frame (word_cnt=15 at end of word): frame_done=1, frame_ready ← 1, state ← IDLE.
- sync=1 in RECV (any bit position, including bit 0 of word 15):
  - frame_error=1 and frame_ready ← 0.
  - Restart as a fresh word 0, with the sampled bit as bit 11. The aborted word produces no word_valid and no frame_done.
  - Bank words already written are left stale.
- sync=1 in IDLE: frame_ready ← 0 as the new frame starts. This is not an error.
- Back-to-back frames: sync on the edge right after the last bit of word 15 is legal. The FSM is in IDLE at that edge, so no error.
- Bank is written only at end of word. rd_data is always bank[rd_addr], with no read latency.
- Reset (async, any time):
  - state=IDLE, shift_reg=0, bit_cnt=0, word_cnt=0.
  - word_data=0, word_index=0, word_valid=0, frame_done=0, frame_error=0, frame_ready=0.
  - All bank entries = 0.
  - A frame in flight is discarded. After reset release, nothing is received until the next sync.

## Timing
- E0 is the edge that samples sync=1 and the MSB of word 0. Word k's LSB is sampled at E(12k+11).
- word_valid is registered at E(12k+11) and high for the single cycle after it. Word data appears 1 cycle after its LSB.
- The bank entry is visible on rd_data in the same cycle as word_valid.
- Frame length is 192 bits. frame_done and frame_ready rise after E191. Minimum frame period is 192 cycles (next sync at E192).
- frame_error is high for the cycle after the sync edge that aborts.
- All strobe outputs are registered single-cycle pulses, never held.
- Bit framing depends only on the sync reference. The receiver assumes sdi is continuous for 192 cycles after sync and does no gap detection.

## Test plan
- Reset values: assert rst_n=0 mid-cycle → all outputs 0 immediately; rd_data=0 for all 16 addresses.
- Nominal frame: sync at E0, words RTC=0xA5C, CHk=k×0x111 (mod 0x1000), MSB first → 16 word_valid pulses 12 cycles apart, word_index 0..15 with matching data; frame_done after E191; frame_ready=1; rd_addr=3 → 0x333.
- Back-to-back: two frames, the second sync at E192 with RTC=0x001 → no frame_error; 32 word_valid pulses; after the second frame, bank[0]=0x001.
- Abort: sync again at E100 (word 8, bit 4) → frame_error pulse; no word_valid for word 8; frame_ready=0; the new frame completes 192 cycles after E100.
- Idle noise: toggle sdi randomly for 50 cycles with no sync → no strobes, bank unchanged.
- Reset mid-frame: rst_n low at E60 → outputs cleared, bank zeroed; after release and a full frame → correct data, frame_ready=1.
